// File: rtl/abc_pattern_sequencer_pkg.sv
// Shared definitions for the {a,b,c} pattern sequencer: state encoding,
// pattern count and default hold length.
package abc_pattern_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int NUM_PATTERNS    = 8;
    localparam int DEF_HOLD_CYCLES = 200;

endpackage

// File: rtl/abc_pattern_sequencer_hold_timer.sv
// Hold-window timer: counts down from HOLD_CYCLES-1 and flags the last clock
// of each window (elapsed count HOLD_CYCLES-1) with a one-cycle terminal pulse.
module abc_pattern_sequencer_hold_timer
    import abc_pattern_sequencer_pkg::*;
#(
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic ld,
    input  logic en,
    output logic tc
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

    // Remaining clocks in the current window; zero on its last clock.
    logic [CW-1:0] rem;

    assign tc = en && (rem == '0);

    always_ff @(posedge clk) begin
        if (!rst_n || clr || ld) begin
            rem <= LAST;
        end else if (en) begin
            rem <= rem - CW'(1);
        end
    end

endmodule

// File: rtl/abc_pattern_sequencer.sv
// Steps {a,b,c} through 000..111, holds each for HOLD_CYCLES clocks and
// captures the datapath output on the last clock of every hold window.
module abc_pattern_sequencer
    import abc_pattern_sequencer_pkg::*;
#(
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int OUT_W       = 2
) (
    input  logic             Clock,
    input  logic             Rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [OUT_W-1:0] dut_out,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             busy,
    output logic             done,
    output logic             result_vld,
    output logic [2:0]       result_code,
    output logic [OUT_W-1:0] result_data,
    input  logic [2:0]       rd_addr,
    output logic [OUT_W-1:0] rd_data
);

    state_t           state;
    logic [2:0]       idx;
    logic [2:0]       abc_q;
    logic             win_end;
    logic [OUT_W-1:0] tbl [NUM_PATTERNS];

    // The timer reloads itself on its own terminal pulse, so back-to-back
    // windows need no extra control; it is parked whenever we are not driving.
    abc_pattern_sequencer_hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_timer (
        .clk   (Clock),
        .rst_n (Rst_n),
        .clr   (state != DRIVE),
        .ld    (win_end),
        .en    (state == DRIVE),
        .tc    (win_end)
    );

    assign {a, b, c} = abc_q;
    assign rd_data   = tbl[rd_addr];

    always_ff @(posedge Clock) begin
        if (!Rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            abc_q       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result_vld  <= 1'b0;
            result_code <= '0;
            result_data <= '0;
            for (int i = 0; i < NUM_PATTERNS; i++) begin
                tbl[i] <= '0;
            end
        end else begin
            done       <= 1'b0;
            result_vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state <= DRIVE;
                        idx   <= '0;
                        abc_q <= '0;
                        busy  <= 1'b1;
                    end
                end
                DRIVE: begin
                    // Abort beats a coincident window close: the partial
                    // pattern is never captured.
                    if (abort) begin
                        state <= IDLE;
                        abc_q <= '0;
                        busy  <= 1'b0;
                    end else if (win_end) begin
                        tbl[idx]    <= dut_out;
                        result_code <= idx;
                        result_data <= dut_out;
                        result_vld  <= 1'b1;
                        if (idx == 3'(NUM_PATTERNS - 1)) begin
                            state <= DONE;
                            abc_q <= '0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            idx   <= idx + 3'd1;
                            abc_q <= idx + 3'd1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_abc_pattern_sequencer.sv
// Randomized scoreboard bench for abc_pattern_sequencer with HOLD_CYCLES=4 and
// a datapath model dut_out = a+b+c+bias (mod 4).
module tb_abc_pattern_sequencer;

    localparam int H = 4;

    logic       Clock = 1'b0;
    logic       Rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] bias  = 2'd0;
    logic [1:0] dut_out;
    logic       a, b, c, busy, done, result_vld;
    logic [2:0] result_code;
    logic [2:0] rd_addr = 3'd0;
    logic [1:0] result_data, rd_data;

    typedef struct {
        int         edge_n;
        logic [2:0] code;
        logic [1:0] data;
        logic       fin;
    } exp_t;

    exp_t       q[$];
    logic [1:0] mtbl [8];
    int         tests = 0, fails = 0;
    int         edge_n = 0, run_start = 0, run_end = 0;
    bit         mon_on = 1'b0;

    abc_pattern_sequencer #(.HOLD_CYCLES(H), .OUT_W(2)) dut (
        .Clock       (Clock),
        .Rst_n       (Rst_n),
        .start       (start),
        .abort       (abort),
        .dut_out     (dut_out),
        .a           (a),
        .b           (b),
        .c           (c),
        .busy        (busy),
        .done        (done),
        .result_vld  (result_vld),
        .result_code (result_code),
        .result_data (result_data),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );

    assign dut_out = {1'b0, a} + {1'b0, b} + {1'b0, c} + bias;

    always #5 Clock = ~Clock;
    always @(posedge Clock) edge_n = edge_n + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic readback;
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            #1;
            chk($sformatf("rd_data[%0d]", i), rd_data, mtbl[i]);
        end
    endtask

    // fate: 0 = run to completion, 1 = abort sampled at edge start+stop_off,
    // 2 = reset sampled at edge start+stop_off.
    task automatic run(input int fate, input int stop_off, input logic [1:0] bv,
                       input bit abort_in_done);
        int e, last, spur;
        bias  = bv;
        start = 1'b1;
        tick;
        start     = 1'b0;
        e         = edge_n;
        run_start = e;
        run_end   = (fate == 0) ? e + 8 * H : e + stop_off;
        for (int k = 0; k < 8; k++) begin
            if (fate == 0 || (k + 1) * H < stop_off)
                q.push_back(exp_t'{e + (k + 1) * H, 3'(k),
                                   2'($countones(3'(k))) + bv, (fate == 0) && (k == 7)});
        end
        last = (fate == 0) ? 8 * H + 1 : stop_off;
        spur = (last > 1) ? int'($urandom_range(last - 1, 1)) : 0;
        for (int o = 1; o <= last; o++) begin
            start = (o == spur) || (fate == 0 && o == last);
            abort = (fate == 1 && o == stop_off) || (abort_in_done && fate == 0 && o == last);
            Rst_n = !(fate == 2 && o == stop_off);
            tick;
        end
        start = 1'b0;
        abort = 1'b0;
        Rst_n = 1'b1;
        if (fate == 2) begin
            for (int k = 0; k < 8; k++) mtbl[k] = 2'd0;
            chk("rst_busy", busy, 0);
            chk("rst_abc", {a, b, c}, 0);
            chk("rst_done", done, 0);
            chk("rst_vld", result_vld, 0);
            chk("rst_code", result_code, 0);
            chk("rst_data", result_data, 0);
        end else begin
            for (int k = 0; k < 8; k++)
                if (fate == 0 || (k + 1) * H < stop_off)
                    mtbl[k] = 2'($countones(3'(k))) + bv;
        end
        repeat (3) tick;
    endtask

    int         mn;
    bit         meb;
    logic [2:0] mea;
    exp_t       me;

    always @(negedge Clock) begin
        if (mon_on) begin
            mn  = edge_n;
            meb = (mn >= run_start) && (mn < run_end);
            mea = meb ? 3'((mn - run_start) / H) : 3'd0;
            chk("busy", busy, meb);
            chk("abc", {a, b, c}, mea);
            if (result_vld || done) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_pulse: vld=%0b done=%0b at edge %0d, expected no pulse",
                             result_vld, done, mn);
                end else begin
                    me = q.pop_front();
                    chk("result_edge", mn, me.edge_n);
                    chk("result_vld", result_vld, 1);
                    chk("done", done, me.fin);
                    chk("result_code", result_code, me.code);
                    chk("result_data", result_data, me.data);
                end
            end else if (q.size() > 0 && q[0].edge_n <= mn) begin
                tests++;
                fails++;
                $display("FAIL missing_result: none at edge %0d, expected code %0d at edge %0d",
                         mn, q[0].code, q[0].edge_n);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        for (int k = 0; k < 8; k++) mtbl[k] = 2'd0;
        Rst_n = 1'b0;
        repeat (5) tick;
        mon_on = 1'b1;
        Rst_n  = 1'b1;
        chk("reset_busy", busy, 0);
        chk("reset_abc", {a, b, c}, 0);
        chk("reset_done", done, 0);
        chk("reset_vld", result_vld, 0);
        chk("reset_code", result_code, 0);
        chk("reset_data", result_data, 0);
        readback;

        // Plain run: data 0,1,1,2,1,2,2,3 with extra starts mid-run and in DONE.
        run(0, 0, 2'd0, 1'b0);
        readback;

        // start+abort together in IDLE, then abort alone in IDLE.
        start = 1'b1;
        abort = 1'b1;
        tick;
        start = 1'b0;
        abort = 1'b0;
        chk("idle_start_abort_busy", busy, 0);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("idle_abort_busy", busy, 0);
        repeat (2) tick;

        // Abort while idx=3, cnt=1.
        run(1, 3 * H + 2, 2'($urandom_range(3, 1)), 1'b0);
        readback;

        repeat (8) begin
            run(int'($urandom_range(1, 0)), int'($urandom_range(8 * H - 1, 1)),
                2'($urandom), 1'($urandom));
            readback;
        end

        // Reset during idx=5.
        run(2, 5 * H + 2, 2'd1, 1'b0);
        readback;

        run(0, 0, 2'd3, 1'b1);
        readback;

        repeat (2) tick;
        chk("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/abc_pattern_sequencer.md
Name: abc_pattern_sequencer

Overview:
- Controller that sequences the three 1-bit inputs (a, b, c) of the block_nonblock datapath through all 8 combinations, 000 to 111.
- Holds each combination for a programmable number of clocks.
- Samples the datapath's 2-bit output at the end of each hold window and stores it in an 8-entry result table.
- Sits between a start/abort control source and the datapath instance; replaces the hand-written stimulus sequence with reusable hardware.

Parameters:
- HOLD_CYCLES, 200, clocks each {a,b,c} combination is held; legal range >= 2.
- OUT_W, 2, width of the datapath output being captured.

Ports:
- Clock  input  1  system clock; all logic on the rising edge.
- Rst_n  input  1  reset, synchronous, active-low.
- start  input  1  run request; honoured only in IDLE.
- abort  input  1  terminate the run; honoured in DRIVE.
- dut_out  input  OUT_W  output of the driven datapath.
- a  output  1  datapath input a.
- b  output  1  datapath input b.
- c  output  1  datapath input c.
- busy  output  1  high while in DRIVE.
- done  output  1  one-cycle pulse, completed run.
- result_vld  output  1  one-cycle pulse, new sample captured.
- result_code  output  3  {a,b,c} combination of the latest sample.
- result_data  output  OUT_W  latest captured dut_out.
- rd_addr  input  3  result table read index.
- rd_data  output  OUT_W  table[rd_addr], combinational read.

Behaviour:
- Reset (Rst_n=0 at a rising edge):
  - state=IDLE; idx=0; cnt=0.
  - a=b=c=0; busy=0; done=0; result_vld=0; result_code=0; result_data=0.
  - All 8 table entries = 0.
  - Reset mid-run drops the run immediately; no done pulse.
- Counter:
  - cnt width is $clog2(HOLD_CYCLES).
  - idx is 3 bits; {a,b,c} = idx, with a as the MSB.
- IDLE:
  - a=b=c=0, busy=0.
  - start=1 and abort=0 → DRIVE, idx=0, cnt=0.
  - start=1 and abort=1 together → stay in IDLE (abort wins).
- DRIVE:
  - busy=1; {a,b,c}=idx, registered, so it changes on the edge after the window closes.
  - cnt increments every clock.
  - At the edge where cnt==HOLD_CYCLES-1:
    - table[idx] <= dut_out.
    - result_code <= idx; result_data <= dut_out.
    - result_vld=1 in the following cycle only.
    - If idx<7: idx <= idx+1, cnt <= 0.
    - If idx==7: go to DONE.
  - Each combination is therefore held for exactly HOLD_CYCLES clocks. Sampling at the last clock gives the datapath HOLD_CYCLES-1 cycles to settle.
- DONE:
  - Lasts exactly one cycle.
  - done=1 coincides with the final result_vld (code 7).
  - busy=0; a=b=c=0; start is ignored.
  - Next state is IDLE.
- Abort:
  - abort=1 in DRIVE → IDLE next edge; a=b=c=0; no result_vld, no done.
  - Table entries already written are retained; the partially held pattern is not captured.
  - abort has no effect in IDLE or DONE.
- start while busy or in DONE is ignored, with no queuing.
- Run length: from the start-accept edge to the done cycle is 8*HOLD_CYCLES clocks.
- The table is not cleared on start; each entry is overwritten when its pattern completes.

Decomposition:
- Shared package (sequencer_pkg) holds:
  - State encoding constants: IDLE=2'd0, DRIVE=2'd1, DONE=2'd2.
  - NUM_PATTERNS=8.
  - Default HOLD_CYCLES=200.
- One natural sub-module: hold_timer.
  - Parameterised down-counter with load and clear.
  - Emits a terminal pulse at count HOLD_CYCLES-1.
  - Reusable by other stimulus controllers.
- Result table and FSM live in the top module.

Test Plan (HOLD_CYCLES=4, datapath model dut_out=a+b+c):
- Reset and run:
  - Stimulus: Rst_n=0 for 5 clocks, release, then start pulse.
  - Required: {a,b,c} steps 000..111, 4 clocks each.
  - Required: result_vld pulses 8 times with data 0,1,1,2,1,2,2,3.
  - Required: done pulses once, 32 clocks after the start-accept edge.
- Table readback:
  - Stimulus: after done, sweep rd_addr 0..7.
  - Required: rd_data = 0,1,1,2,1,2,2,3.
- Abort mid-run:
  - Stimulus: abort during idx=3, cnt=1.
  - Required: IDLE next cycle; a=b=c=0, busy=0.
  - Required: no done pulse; table[0..2] hold the new values; table[3..7] unchanged.
- Start ignored:
  - Stimulus: start re-pulsed while busy, and again in the DONE cycle.
  - Required: run length unchanged; only one done pulse.
- Simultaneous start and abort in IDLE:
  - Required: stays in IDLE, busy=0.
- Reset mid-run:
  - Stimulus: Rst_n=0 during idx=5.
  - Required: all outputs and table entries = 0 at the next edge.
  - Required: no done pulse.
